q100_itcm_arb: RTL and testbench
================================

Name: q100_itcm_arb

Overview:
Two-requester arbiter and sequencer in front of the single-port ITCM RAM. The ITCM has 1-cycle read latency, word-addressed by addr[11:2]. One requester is instruction fetch (IFU, read-only); the other is the load/store path (LSU, read/write). The block grants one access per cycle, tracks which requester owns the in-flight read, and routes read data back to it. It prevents IFU starvation under sustained LSU traffic.

Parameters:
ITCM_DATA_WIDTH, 32, data word width
ITCM_ADDR_WIDTH, 12, byte address width (word index = addr[ITCM_ADDR_WIDTH-1:2])
STARVE_LIMIT, 4, consecutive denied IFU cycles before IFU is forced to win (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ifu_req_i  in  1  IFU read request
ifu_addr_i  in  ITCM_ADDR_WIDTH  IFU byte address
ifu_flush_i  in  1  discard any pending IFU response; block IFU grant this cycle
ifu_gnt_o  out  1  IFU request accepted this cycle
ifu_rvalid_o  out  1  IFU read data valid
ifu_rdata_o  out  ITCM_DATA_WIDTH  IFU read data
lsu_req_i  in  1  LSU request
lsu_we_i  in  1  LSU write (1) / read (0)
lsu_addr_i  in  ITCM_ADDR_WIDTH  LSU byte address
lsu_wdata_i  in  ITCM_DATA_WIDTH  LSU write data
lsu_gnt_o  out  1  LSU request accepted this cycle
lsu_rvalid_o  out  1  LSU response valid (read data, or write ack)
lsu_rdata_o  out  ITCM_DATA_WIDTH  LSU read data
itcm_addr_o  out  ITCM_ADDR_WIDTH  RAM byte address
itcm_we_o  out  1  RAM write enable
itcm_wdata_o  out  ITCM_DATA_WIDTH  RAM write data
itcm_rdata_i  in  ITCM_DATA_WIDTH  RAM read data, valid 1 cycle after the address

Behaviour:
- Clock is clk; reset is rst, synchronous, active-high. No other clocks.
- Reset effects:
  - Starve counter = 0, pending-owner register = NONE.
  - ifu_rvalid_o = lsu_rvalid_o = 0.
  - ifu_gnt_o = lsu_gnt_o = itcm_we_o = 0 while rst = 1.
  - Asserting rst mid-operation drops any in-flight response; no rvalid follows.
- Grant is combinational, in the same cycle as the request. At most one grant per cycle. Requesters hold req/addr/wdata stable until granted.
- Arbitration order:
  - ifu_eff = ifu_req_i & ~ifu_flush_i.
  - If ifu_eff and starve_cnt == STARVE_LIMIT: grant IFU.
  - Else if lsu_req_i: grant LSU.
  - Else if ifu_eff: grant IFU.
- Starve counter (4 bits):
  - Increments, saturating at STARVE_LIMIT, when ifu_eff = 1 and LSU is granted.
  - Clears to 0 on IFU grant or when ifu_eff = 0.
- RAM drive:
  - itcm_addr_o = lsu_addr_i when LSU is granted, else ifu_addr_i.
  - itcm_we_o = lsu_gnt_o & lsu_we_i.
  - itcm_wdata_o = lsu_wdata_i.
  - Word writes only; addr[1:0] ignored.
- Response tracking: pending-owner register is loaded each cycle with IFU_RD, LSU_RD, LSU_WR, or NONE.
- Responses appear in cycle N+1 for a grant in cycle N:
  - IFU_RD: ifu_rvalid_o = 1, ifu_rdata_o = itcm_rdata_i.
  - LSU_RD: lsu_rvalid_o = 1, lsu_rdata_o = itcm_rdata_i.
  - LSU_WR: lsu_rvalid_o = 1, lsu_rdata_o = 0.
  - Otherwise rdata outputs = 0.
- Flush: ifu_flush_i = 1 in cycle N+1 suppresses ifu_rvalid_o for an IFU read granted in cycle N. LSU responses are unaffected.
- Back-to-back grants are allowed every cycle; throughput is 1 access/cycle. There is no response backpressure: requesters must accept rvalid.
- Read-after-write to the same address in consecutive cycles returns the new data, since the RAM write completes before the next read.

Test Plan:
1. IFU-only reads of 0x000, 0x004, 0x008 in consecutive cycles, RAM preloaded 0x11,0x22,0x33 -> ifu_gnt_o = 1 each cycle; ifu_rvalid_o 1 cycle later with 0x11, 0x22, 0x33; lsu_rvalid_o stays 0.
2. IFU and LSU both request continuously, STARVE_LIMIT = 4 -> LSU granted cycles 0-3, IFU granted cycle 4, LSU granted cycles 5-8, IFU cycle 9; rvalid routing matches each grant.
3. LSU writes 0xDEADBEEF to 0x010, then IFU reads 0x010 next cycle -> lsu_rvalid_o = 1 with rdata 0 after the write; ifu_rdata_o = 0xDEADBEEF.
4. Flush:
   - IFU granted read at cycle N, ifu_flush_i = 1 at N+1 -> ifu_rvalid_o stays 0.
   - ifu_req_i and ifu_flush_i both high, no LSU request -> ifu_gnt_o = 0, starve counter stays 0.
5. Reset mid-operation: LSU read granted at cycle N, rst = 1 at N+1 -> lsu_rvalid_o = 0 at N+1 and N+2; after rst drops, counter restarts from 0 (IFU needs 4 more denials to win).
6. LSU read 0x020 (value 0xA5A5A5A5) with simultaneous IFU request, starve_cnt = 0 -> LSU granted; next cycle lsu_rdata_o = 0xA5A5A5A5 and IFU granted; ifu_rdata_o never shows LSU data.

Source files
------------

// File: rtl/q100_itcm_arb.sv
// Arbitrates IFU fetches and LSU loads/stores onto the single-port ITCM and
// routes each 1-cycle-latency response back to the requester that owns it.
module q100_itcm_arb #(
  parameter int ITCM_DATA_WIDTH = 32,
  parameter int ITCM_ADDR_WIDTH = 12,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ifu_req_i,
  input  logic [ITCM_ADDR_WIDTH-1:0] ifu_addr_i,
  input  logic                       ifu_flush_i,
  output logic                       ifu_gnt_o,
  output logic                       ifu_rvalid_o,
  output logic [ITCM_DATA_WIDTH-1:0] ifu_rdata_o,
  input  logic                       lsu_req_i,
  input  logic                       lsu_we_i,
  input  logic [ITCM_ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [ITCM_DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                       lsu_gnt_o,
  output logic                       lsu_rvalid_o,
  output logic [ITCM_DATA_WIDTH-1:0] lsu_rdata_o,
  output logic [ITCM_ADDR_WIDTH-1:0] itcm_addr_o,
  output logic                       itcm_we_o,
  output logic [ITCM_DATA_WIDTH-1:0] itcm_wdata_o,
  input  logic [ITCM_DATA_WIDTH-1:0] itcm_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE   = 2'd0,
    OWN_IFU_RD = 2'd1,
    OWN_LSU_RD = 2'd2,
    OWN_LSU_WR = 2'd3
  } owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_q, starve_d;
  owner_e     owner_q, owner_d;
  logic       ifu_eff;
  logic       ifu_gnt;
  logic       lsu_gnt;

  // LSU normally wins; IFU is forced through once it has been denied LIMIT times.
  always_comb begin
    ifu_eff = ifu_req_i & ~ifu_flush_i;
    ifu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if (!rst) begin
      if (ifu_eff && (starve_q == LIMIT)) begin
        ifu_gnt = 1'b1;
      end else if (lsu_req_i) begin
        lsu_gnt = 1'b1;
      end else if (ifu_eff) begin
        ifu_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = 4'd0;
    if (ifu_eff && lsu_gnt) begin
      starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
    end
    owner_d = OWN_NONE;
    if (ifu_gnt) begin
      owner_d = OWN_IFU_RD;
    end else if (lsu_gnt) begin
      owner_d = lsu_we_i ? OWN_LSU_WR : OWN_LSU_RD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 4'd0;
      owner_q  <= OWN_NONE;
    end else begin
      starve_q <= starve_d;
      owner_q  <= owner_d;
    end
  end

  assign ifu_gnt_o    = ifu_gnt;
  assign lsu_gnt_o    = lsu_gnt;
  assign itcm_addr_o  = lsu_gnt ? lsu_addr_i : ifu_addr_i;
  assign itcm_we_o    = lsu_gnt & lsu_we_i;
  assign itcm_wdata_o = lsu_wdata_i;

  // Reset in the response cycle kills the response even though owner_q is still set.
  assign ifu_rvalid_o = (owner_q == OWN_IFU_RD) & ~ifu_flush_i & ~rst;
  assign ifu_rdata_o  = ifu_rvalid_o ? itcm_rdata_i : '0;
  assign lsu_rvalid_o = ((owner_q == OWN_LSU_RD) | (owner_q == OWN_LSU_WR)) & ~rst;
  assign lsu_rdata_o  = ((owner_q == OWN_LSU_RD) && !rst) ? itcm_rdata_i : '0;

endmodule

// File: tb/tb_q100_itcm_arb.sv
// Bench for q100_itcm_arb: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural arbitration model.
module tb_q100_itcm_arb;

  localparam int DW    = 32;
  localparam int AW    = 12;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req, ifu_flush, ifu_gnt, ifu_rvalid;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [AW-1:0] itcm_addr;
  logic          itcm_we;
  logic [DW-1:0] itcm_wdata, itcm_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] ram     [1024];
  logic [DW-1:0] ref_mem [1024];

  always #5 clk = ~clk;

  q100_itcm_arb #(
    .ITCM_DATA_WIDTH(DW),
    .ITCM_ADDR_WIDTH(AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .ifu_req_i(ifu_req), .ifu_addr_i(ifu_addr), .ifu_flush_i(ifu_flush),
    .ifu_gnt_o(ifu_gnt), .ifu_rvalid_o(ifu_rvalid), .ifu_rdata_o(ifu_rdata),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_gnt_o(lsu_gnt), .lsu_rvalid_o(lsu_rvalid),
    .lsu_rdata_o(lsu_rdata), .itcm_addr_o(itcm_addr), .itcm_we_o(itcm_we),
    .itcm_wdata_o(itcm_wdata), .itcm_rdata_i(itcm_rdata)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    logic [DW-1:0] w;
    w = 32'hC0DE_0000 | 32'(i);
    if (i == 0) w = 32'h11;
    if (i == 1) w = 32'h22;
    if (i == 2) w = 32'h33;
    if (i == 8) w = 32'hA5A5_A5A5;
    return w;
  endfunction

  // Single-port RAM, 1-cycle read latency, write visible to the next read.
  initial for (int i = 0; i < 1024; i++) ram[i] <= init_word(i);
  always @(posedge clk) begin
    if (itcm_we) ram[itcm_addr[AW-1:2]] <= itcm_wdata;
    itcm_rdata <= ram[itcm_addr[AW-1:2]];
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: denial count, and the one response owed next cycle.
  int            m_starve = 0;
  int            m_pend   = 0;  // 0 none, 1 IFU read, 2 LSU read, 3 LSU write
  logic [DW-1:0] m_data   = '0;

  initial for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);

  always @(negedge clk) begin
    logic ifu_eff, eg_i, eg_l;
    ifu_eff = ifu_req && !ifu_flush;
    eg_i = 1'b0;
    eg_l = 1'b0;
    if (!rst) begin
      if (ifu_eff && m_starve >= LIMIT) eg_i = 1'b1;
      else if (lsu_req)                 eg_l = 1'b1;
      else if (ifu_eff)                 eg_i = 1'b1;
    end
    chk("m_ifu_gnt", 32'(ifu_gnt), 32'(eg_i));
    chk("m_lsu_gnt", 32'(lsu_gnt), 32'(eg_l));
    chk("m_itcm_we", 32'(itcm_we), 32'(eg_l && lsu_we));
    chk("m_itcm_wdata", itcm_wdata, lsu_wdata);
    if (eg_l) chk("m_itcm_addr_lsu", 32'(itcm_addr), 32'(lsu_addr));
    if (eg_i) chk("m_itcm_addr_ifu", 32'(itcm_addr), 32'(ifu_addr));
    chk("m_ifu_rvalid", 32'(ifu_rvalid), 32'(!rst && m_pend == 1 && !ifu_flush));
    if (!(m_pend == 1 && (ifu_flush || rst)))
      chk("m_ifu_rdata", ifu_rdata, (!rst && m_pend == 1) ? m_data : '0);
    chk("m_lsu_rvalid", 32'(lsu_rvalid), 32'(!rst && m_pend >= 2));
    chk("m_lsu_rdata", lsu_rdata, (!rst && m_pend == 2) ? m_data : '0);
    if (rst) begin
      m_starve = 0;
      m_pend   = 0;
    end else begin
      if (eg_l && ifu_eff) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      else                 m_starve = 0;
      m_pend = 0;
      if (eg_i) begin
        m_pend = 1;
        m_data = ref_mem[ifu_addr[AW-1:2]];
      end else if (eg_l && !lsu_we) begin
        m_pend = 2;
        m_data = ref_mem[lsu_addr[AW-1:2]];
      end else if (eg_l) begin
        m_pend = 3;
        ref_mem[lsu_addr[AW-1:2]] = lsu_wdata;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ig, lg;
    rst = 1'b1; ifu_req = 1'b1; ifu_addr = '0; ifu_flush = 1'b0;
    lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = '0; lsu_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("rst_ifu_gnt", 32'(ifu_gnt), 0);
    chk("rst_lsu_gnt", 32'(lsu_gnt), 0);
    chk("rst_we", 32'(itcm_we), 0);
    chk("rst_rvalid", 32'({ifu_rvalid, lsu_rvalid}), 0);
    tick(); tick();
    rst = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0;

    // IFU-only streaming reads
    tick(); ifu_req = 1'b1; ifu_addr = 12'h000;
    @(negedge clk); chk("t1_gnt0", 32'(ifu_gnt), 1);
    tick(); ifu_addr = 12'h004;
    @(negedge clk); chk("t1_rd0", ifu_rdata, 32'h11); chk("t1_rv0", 32'(ifu_rvalid), 1);
    tick(); ifu_addr = 12'h008;
    @(negedge clk); chk("t1_rd1", ifu_rdata, 32'h22); chk("t1_lsu_rv", 32'(lsu_rvalid), 0);
    tick(); ifu_req = 1'b0;
    @(negedge clk); chk("t1_rd2", ifu_rdata, 32'h33); chk("t1_rv2", 32'(ifu_rvalid), 1);

    // Sustained contention: IFU wins every fifth cycle
    ifu_addr = 12'h000; lsu_addr = 12'h040; lsu_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); ifu_req = 1'b1; lsu_req = 1'b1;
      @(negedge clk);
      chk($sformatf("t2_lsu_gnt%0d", i), 32'(lsu_gnt), 32'(i != 4 && i != 9));
      chk($sformatf("t2_ifu_gnt%0d", i), 32'(ifu_gnt), 32'(i == 4 || i == 9));
    end
    tick(); ifu_req = 1'b0; lsu_req = 1'b0;
    @(negedge clk); chk("t2_ifu_rd", ifu_rdata, 32'h11); chk("t2_lsu_rv", 32'(lsu_rvalid), 0);

    // Write then read-back of the same word
    tick(); lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 12'h010; lsu_wdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("t3_we", 32'(itcm_we), 1);
    tick(); lsu_req = 1'b0; lsu_we = 1'b0; ifu_req = 1'b1; ifu_addr = 12'h010;
    @(negedge clk); chk("t3_wr_ack", 32'(lsu_rvalid), 1); chk("t3_wr_rd", lsu_rdata, 0);
    tick(); ifu_req = 1'b0;
    @(negedge clk); chk("t3_raw", ifu_rdata, 32'hDEAD_BEEF);

    // Flush of an in-flight fetch, and flush blocking a new fetch
    tick(); ifu_req = 1'b1; ifu_addr = 12'h004;
    @(negedge clk); chk("t4_gnt", 32'(ifu_gnt), 1);
    tick(); ifu_flush = 1'b1;
    @(negedge clk); chk("t4_rv_flushed", 32'(ifu_rvalid), 0); chk("t4_gnt_blk", 32'(ifu_gnt), 0);

    // Reset between an LSU grant and its response
    tick(); ifu_flush = 1'b0; lsu_req = 1'b1; lsu_addr = 12'h020;
    @(negedge clk); chk("t5_lsu_gnt_a", 32'(lsu_gnt), 1);
    tick();
    @(negedge clk); chk("t5_lsu_gnt_n", 32'(lsu_gnt), 1);
    tick(); rst = 1'b1;
    @(negedge clk); chk("t5_rv_in_rst", 32'(lsu_rvalid), 0); chk("t5_gnt_in_rst", 32'(lsu_gnt), 0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      @(negedge clk);
      if (k == 0) chk("t5_rv_after_rst", 32'(lsu_rvalid), 0);
      chk($sformatf("t5_ifu_gnt%0d", k), 32'(ifu_gnt), 32'(k == 4));
    end

    // LSU read wins over a fresh IFU request; data goes only to LSU
    tick(); ifu_req = 1'b0; lsu_req = 1'b0;
    @(negedge clk);
    tick(); lsu_req = 1'b1; lsu_addr = 12'h020; ifu_req = 1'b1; ifu_addr = 12'h008;
    @(negedge clk); chk("t6_lsu_gnt", 32'(lsu_gnt), 1); chk("t6_ifu_wait", 32'(ifu_gnt), 0);
    tick(); lsu_req = 1'b0;
    @(negedge clk);
    chk("t6_lsu_rd", lsu_rdata, 32'hA5A5_A5A5);
    chk("t6_ifu_gnt", 32'(ifu_gnt), 1);
    chk("t6_ifu_rd_clean", ifu_rdata, 0);
    tick(); ifu_req = 1'b0;
    @(negedge clk); chk("t6_ifu_rd", ifu_rdata, 32'h33);

    // Randomized traffic, requests held until granted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ig = ifu_gnt;
      lg = lsu_gnt;
      tick();
      rst = ($urandom_range(0, 99) == 0);
      ifu_flush = ($urandom_range(0, 7) == 0);
      if (!ifu_req || ig) begin
        ifu_req  = ($urandom_range(0, 2) != 0);
        ifu_addr = AW'($urandom_range(0, 255));
      end
      if (!lsu_req || lg) begin
        lsu_req  = ($urandom_range(0, 2) != 0);
        lsu_we   = $urandom_range(0, 1) == 1;
        lsu_addr = AW'($urandom_range(0, 255));
      end
      lsu_wdata = $urandom;
    end

    tick(); rst = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0; ifu_flush = 1'b0;
    @(negedge clk);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
